// File: rtl/mmio_port_responder.sv
// MMIO responder: PortOut register, synchronized PortIn with change flag,
// optional timer/compare. Optional timer is built when MMIO_TIMER_EN is defined.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        IRQ
);

  localparam logic [2:0] OFF_OUT  = 3'd0;
  localparam logic [2:0] OFF_IN   = 3'd1;
  localparam logic [2:0] OFF_STAT = 3'd2;
  localparam logic [2:0] OFF_TMR  = 3'd3;
  localparam logic [2:0] OFF_CMP  = 3'd4;

  logic [2:0] sel;
  logic       wr;
  logic       rd;
  logic       sel_out;
  logic       sel_in;
  logic       sel_stat;
  logic       sel_tmr;
  logic       sel_cmp;
  logic       unused_addr;

  assign sel = Address[4:2];
  assign Hit = (Address[31:5] == BASE_ADDR[31:5])
            && (sel <= OFF_CMP);
  assign wr  = MemWrite && Hit;
  assign rd  = MemRead && Hit;

  // Sub-word byte offset carries no meaning here.
  assign unused_addr = ^Address[1:0];

  assign sel_out  = (sel == OFF_OUT);
  assign sel_in   = (sel == OFF_IN);
  assign sel_stat = (sel == OFF_STAT);
  assign sel_tmr  = (sel == OFF_TMR);
  assign sel_cmp  = (sel == OFF_CMP);

  logic [31:0] out_q, out_d;
  logic [7:0]  s1_q, s2_q, s3_q;
  logic [1:0]  stat_q, stat_d;
  logic        irq_q, irq_d;
  logic        in_set;
  logic        tmr_set;
  logic [31:0] tmr_rd;
  logic [31:0] cmp_rd;

  assign in_set = (s2_q != s3_q);

`ifdef MMIO_TIMER_EN
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] cmp_q, cmp_d;
  logic        wr_tmr;
  logic        wr_cmp;

  assign wr_tmr = wr && sel_tmr;
  assign wr_cmp = wr && sel_cmp;

  // A load replaces the increment for that cycle.
  always_comb begin
    tmr_d = tmr_q + 32'd1;
    cmp_d = cmp_q;
    if (wr_tmr) tmr_d = WriteData;
    if (wr_cmp) cmp_d = WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_q <= '0;
      cmp_q <= '1;
    end else begin
      tmr_q <= tmr_d;
      cmp_q <= cmp_d;
    end
  end

  assign tmr_set = (tmr_q == cmp_q);
  assign tmr_rd  = tmr_q;
  assign cmp_rd  = cmp_q;
`else
  assign tmr_set = 1'b0;
  assign tmr_rd  = '0;
  assign cmp_rd  = '0;
`endif

  // Set beats a same-edge W1C clear.
  always_comb begin
    out_d  = out_q;
    stat_d = stat_q;
    if (wr && sel_out) out_d = WriteData;
    if (wr && sel_stat) stat_d = stat_q & ~WriteData[1:0];
    if (in_set) stat_d[0] = 1'b1;
    if (tmr_set) stat_d[1] = 1'b1;
    irq_d = |stat_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      stat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      s1_q   <= PortIn;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      stat_q <= stat_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    ReadData = '0;
    if (rd) begin
      unique case (1'b1)
        sel_out:  ReadData = out_q;
        sel_in:   ReadData = {24'b0, s2_q};
        sel_stat: ReadData = {30'b0, stat_q};
        sel_tmr:  ReadData = tmr_rd;
        sel_cmp:  ReadData = cmp_rd;
        default:  ReadData = '0;
      endcase
    end
  end

  assign PortOut = out_q;
  assign IRQ     = irq_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder; expectations go through
// a scoreboard queue and are popped when the DUT output is sampled.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0100;
`ifdef MMIO_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        IRQ;

  always #5 clk = ~clk;

  mmio_port_responder #(.BASE_ADDR(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .Address(Address),
    .WriteData(WriteData),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .ReadData(ReadData),
    .Hit(Hit),
    .PortIn(PortIn),
    .PortOut(PortOut),
    .IRQ(IRQ)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty: got %h required a queued entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [7:0] off, input logic [31:0] d);
    Address   = BASE + {24'b0, off};
    WriteData = d;
    MemWrite  = 1'b1;
    cyc();
    MemWrite  = 1'b0;
    WriteData = '0;
  endtask

  task automatic load(input logic [7:0] off, input string tag,
                      input logic [31:0] exp);
    Address = BASE + {24'b0, off};
    MemRead = 1'b1;
    push(tag, exp);
    #1;
    pop_chk(ReadData);
    MemRead = 1'b0;
  endtask

  task automatic see_irq(input string tag, input logic exp);
    push(tag, {31'b0, exp});
    pop_chk({31'b0, IRQ});
  endtask

  task automatic probe(input logic [31:0] a, input string tag,
                       input logic hit, input logic [31:0] rd);
    Address = a;
    MemRead = 1'b1;
    push({tag, "_hit"}, {31'b0, hit});
    push({tag, "_rd"}, rd);
    #1;
    pop_chk({31'b0, Hit});
    pop_chk(ReadData);
    MemRead = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    Address   = BASE;
    WriteData = 32'hA5;
    PortIn    = 8'h00;
    cyc();
    cyc();

    // reset held during a store
    push("rst_portout", 32'h0);
    pop_chk(PortOut);
    see_irq("rst_irq", 1'b0);
    load(8'h08, "rst_status", 32'h0);
    load(8'h10, "rst_compare", TMR ? 32'hFFFF_FFFF : 32'h0);

    Address   = BASE;
    WriteData = 32'hA5;
    MemWrite  = 1'b1;
    reset     = 1'b1;
    cyc();
    MemWrite  = 1'b0;
    push("store_portout", 32'hA5);
    pop_chk(PortOut);
    load(8'h00, "load_portout", 32'hA5);

    // read without MemRead returns 0
    Address = BASE;
    push("noread_rd", 32'h0);
    #1;
    pop_chk(ReadData);

    // read and write in the same cycle
    Address   = BASE;
    WriteData = 32'h5A;
    MemWrite  = 1'b1;
    MemRead   = 1'b1;
    push("rw_preval", 32'hA5);
    #1;
    pop_chk(ReadData);
    cyc();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    push("rw_postval", 32'h5A);
    pop_chk(PortOut);

    // input synchronizer and change flag
    PortIn = 8'h3C;
    cyc();
    load(8'h04, "in_edge1", 32'h0);
    cyc();
    load(8'h04, "in_edge2", 32'h3C);
    load(8'h08, "chg_edge2", 32'h0);
    see_irq("irq_edge2", 1'b0);
    cyc();
    load(8'h08, "chg_edge3", 32'h1);
    see_irq("irq_edge3", 1'b1);

    // decode boundaries
    probe(BASE + 32'h14, "dec_0x14", 1'b0, 32'h0);
    probe(BASE - 32'h4, "dec_m4", 1'b0, 32'h0);
    probe(BASE + 32'h07, "dec_0x07", 1'b1, 32'h3C);
    probe(BASE + 32'h10, "dec_0x10", 1'b1,
          TMR ? 32'hFFFF_FFFF : 32'h0);

    // PORT_IN is read-only
    store(8'h04, 32'hFFFF_FFFF);
    load(8'h04, "in_ro", 32'h3C);

    // W1C clear
    store(8'h08, 32'h0);
    load(8'h08, "w1c_zero", 32'h1);
    store(8'h08, 32'h1);
    load(8'h08, "w1c_clear", 32'h0);
    cyc();
    see_irq("irq_cleared", 1'b0);

    // set wins against same-edge clear
    PortIn = 8'hC3;
    cyc();
    cyc();
    store(8'h08, 32'h1);
    load(8'h08, "race_set", 32'h1);
    see_irq("race_irq", 1'b1);
    store(8'h08, 32'h1);
    cyc();
    load(8'h08, "race_clr", 32'h0);
    see_irq("race_irq_clr", 1'b0);

    // timer wrap and compare match
    store(8'h0C, 32'hFFFF_FFFE);
    store(8'h10, 32'h0000_0001);
    cyc();
    load(8'h0C, "tmr_wrap", 32'h0);
    load(8'h10, "cmp_rd", TMR ? 32'h1 : 32'h0);
    cyc();
    load(8'h0C, "tmr_one", TMR ? 32'h1 : 32'h0);
    load(8'h08, "match_early", 32'h0);
    cyc();
    load(8'h08, "match_set", TMR ? 32'h2 : 32'h0);
    see_irq("match_irq", TMR);

    // asynchronous reset mid-cycle
    store(8'h00, 32'h1234_5678);
    reset = 1'b0;
    #1;
    push("arst_portout", 32'h0);
    pop_chk(PortOut);
    see_irq("arst_irq", 1'b0);
    load(8'h08, "arst_status", 32'h0);
    load(8'h10, "arst_compare", TMR ? 32'hFFFF_FFFF : 32'h0);
    reset = 1'b1;
    cyc();

    if (sb.size() != 0) begin
      n_chk++;
      $error("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
